// File: rtl/apb_cfg_responder.sv
// rtl/apb_cfg_responder.sv - APB3 completer for accelerator config/status registers and start/done handshake.
// Optional build macro APB_PSLVERR_EN: error response for unmapped addresses and STDN writes during a run.
module apb_cfg_responder #(
  parameter int REG_ADDRWIDTH = 8,
  parameter int REG_DATAWIDTH = 32,
  parameter int WAIT_CYCLES   = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [REG_ADDRWIDTH-1:0] PADDR,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [REG_DATAWIDTH-1:0] PWDATA,
  output logic [REG_DATAWIDTH-1:0] PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic                     enable_matmul,
  output logic                     enable_norm,
  output logic                     enable_activation,
  output logic                     enable_pool,
  output logic [7:0]               mean,
  output logic [7:0]               inv_var,
  output logic                     start_tpu,
  input  logic                     done_tpu
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_ENABLES = REG_ADDRWIDTH'(8'h00);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_STDN    = REG_ADDRWIDTH'(8'h04);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_MEAN    = REG_ADDRWIDTH'(8'h08);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_INV_VAR = REG_ADDRWIDTH'(8'h0C);

  state_t state, state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] enables;
  logic [7:0] mean_q, inv_var_q;
  logic       start_q, done_q;

  logic sel_en, sel_stdn, sel_mean, sel_inv;
  logic xfer_err, wr_commit, rd_load;
  logic [REG_DATAWIDTH-1:0] rdata_mux;
  logic unused_pwdata;

  assign sel_en   = (PADDR == ADDR_ENABLES);
  assign sel_stdn = (PADDR == ADDR_STDN);
  assign sel_mean = (PADDR == ADDR_MEAN);
  assign sel_inv  = (PADDR == ADDR_INV_VAR);

`ifdef APB_PSLVERR_EN
  logic mapped;
  assign mapped   = sel_en | sel_stdn | sel_mean | sel_inv;
  // A run in flight owns STDN; the host must wait for done before rewriting it.
  assign xfer_err = ~mapped | (PWRITE & sel_stdn & start_q & ~done_q);
`else
  assign xfer_err = 1'b0;
`endif

  assign PREADY    = PSEL & PENABLE & (wait_cnt == WAIT_LIM);
  assign PSLVERR   = PREADY & xfer_err;
  assign wr_commit = PREADY & PWRITE & ~xfer_err;
  // Reads sample in the setup phase and refresh through wait states, then hold.
  assign rd_load   = PSEL & ~PWRITE & (~PENABLE | ((state != IDLE) & ~PREADY));

  assign unused_pwdata = ^PWDATA[REG_DATAWIDTH-1:8];

  always_comb begin
    rdata_mux = '0;
    if (sel_en)   rdata_mux[3:0] = enables;
    if (sel_stdn) begin
      rdata_mux[0]  = start_q;
      rdata_mux[31] = done_q;
    end
    if (sel_mean) rdata_mux[7:0] = mean_q;
    if (sel_inv)  rdata_mux[7:0] = inv_var_q;
  end

  always_comb begin
    state_nxt = state;
    if (!PSEL) begin
      state_nxt = IDLE;
    end else if (!PENABLE) begin
      state_nxt = SETUP;
    end else begin
      case (state)
        SETUP:   state_nxt = ACCESS;
        ACCESS:  state_nxt = ACCESS;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (!PSEL || !PENABLE) begin
        wait_cnt <= 4'd0;
      end else if ((state != IDLE) && (wait_cnt < WAIT_LIM)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      PRDATA <= '0;
    end else if (rd_load) begin
      PRDATA <= rdata_mux;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enables   <= 4'd0;
      mean_q    <= 8'd0;
      inv_var_q <= 8'd0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (wr_commit && sel_en)   enables   <= PWDATA[3:0];
      if (wr_commit && sel_mean) mean_q    <= PWDATA[7:0];
      if (wr_commit && sel_inv)  inv_var_q <= PWDATA[7:0];
      // A host start write overrides a coincident completion pulse.
      if (wr_commit && sel_stdn) begin
        start_q <= PWDATA[0];
        if (PWDATA[0]) done_q <= 1'b0;
      end else if (start_q && done_tpu) begin
        start_q <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign enable_matmul     = enables[0];
  assign enable_norm       = enables[1];
  assign enable_activation = enables[2];
  assign enable_pool       = enables[3];
  assign mean              = mean_q;
  assign inv_var           = inv_var_q;
  assign start_tpu         = start_q;

endmodule

// File: tb/tb_apb_cfg_responder.sv
// tb/tb_apb_cfg_responder.sv - scoreboard bench for apb_cfg_responder (zero-wait and 3-wait instances).
module tb_apb_cfg_responder;

`ifdef APB_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  paddr = '0;
  logic        pwrite = 1'b0;
  logic        psel0 = 1'b0, psel1 = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] pwdata = '0;
  logic        done_tpu = 1'b0;

  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic        em0, en0, ea0, ep0, em1, en1, ea1, ep1;
  logic [7:0]  mean0, inv0, mean1, inv1;
  logic        start0, start1;

  always #5 clk = ~clk;

  apb_cfg_responder #(.REG_ADDRWIDTH(8), .REG_DATAWIDTH(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel0),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .enable_matmul(em0), .enable_norm(en0),
    .enable_activation(ea0), .enable_pool(ep0), .mean(mean0), .inv_var(inv0),
    .start_tpu(start0), .done_tpu(done_tpu)
  );

  apb_cfg_responder #(.REG_ADDRWIDTH(8), .REG_DATAWIDTH(32), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .resetn(resetn), .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel1),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .enable_matmul(em1), .enable_norm(en1),
    .enable_activation(ea1), .enable_pool(ep1), .mean(mean1), .inv_var(inv1),
    .start_tpu(start1), .done_tpu(done_tpu)
  );

  typedef struct packed {
    logic [15:0] id;
    logic        is_read;
    logic [31:0] rdata;
    logic        slverr;
    logic [3:0]  waits;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   txn_id = 0;
  int   acc_cnt = 0;

  logic        mon_psel, mon_pready, mon_pslverr;
  logic [31:0] mon_prdata;
  assign mon_psel    = psel0 | psel1;
  assign mon_pready  = psel1 ? pready1 : pready0;
  assign mon_pslverr = psel1 ? pslverr1 : pslverr0;
  assign mon_prdata  = psel1 ? prdata1 : prdata0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed transfer.
  always @(negedge clk) begin
    if (mon_psel && penable) begin
      acc_cnt++;
      if (mon_pready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pready act=1 exp=0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_read) chk($sformatf("rsp%0d_rdata", e.id), 64'(mon_prdata), 64'(e.rdata));
          chk($sformatf("rsp%0d_slverr", e.id), 64'(mon_pslverr), 64'(e.slverr));
          chk($sformatf("rsp%0d_waits", e.id), 64'(acc_cnt - 1), 64'(e.waits));
        end
        acc_cnt = 0;
      end
    end else begin
      acc_cnt = 0;
    end
  end

  function automatic logic addr_err(input logic [7:0] a);
    return (a == 8'h00 || a == 8'h04 || a == 8'h08 || a == 8'h0C) ? 1'b0 : ERR_EN;
  endfunction

  task automatic apb(input int sel, input logic wr, input logic [7:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd);
    exp_t e;
    logic got;
    e.id = 16'(txn_id);
    e.is_read = ~wr;
    e.rdata = exp_rd;
    e.slverr = addr_err(addr);
    e.waits = (sel != 0) ? 4'd3 : 4'd0;
    txn_id++;
    exp_q.push_back(e);
    @(posedge clk); #1;
    paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
    if (sel != 0) psel1 = 1'b1; else psel0 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      got = (sel != 0) ? pready1 : pready0;
    end
    if (!got) begin
      chk($sformatf("txn%0d_timeout", e.id), 64'd0, 64'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input int sel, input logic [7:0] addr, input logic [31:0] d);
    apb(sel, 1'b1, addr, d, 32'h0);
  endtask

  task automatic rd(input int sel, input logic [7:0] addr, input logic [31:0] exp);
    apb(sel, 1'b0, addr, 32'h0, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out0", 64'({prdata0, pready0, pslverr0, ep0, ea0, en0, em0, mean0, inv0, start0}), 64'd0);
    chk("reset_out1", 64'({prdata1, pready1, pslverr1, ep1, ea1, en1, em1, mean1, inv1, start1}), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Reset asserted during an in-flight write on the wait-state instance
    wr(1, 8'h00, 32'h0000_000F);
    chk("pre_reset_en1", 64'({ep1, ea1, en1, em1}), 64'hF);
    @(posedge clk); #1;
    paddr = 8'h00; pwrite = 1'b1; pwdata = 32'h0000_0003; psel1 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #2;
    resetn = 1'b0; psel1 = 1'b0; penable = 1'b0;
    #1;
    chk("async_reset_out1", 64'({prdata1, pready1, pslverr1, ep1, ea1, en1, em1, mean1, inv1, start1}), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    rd(1, 8'h00, 32'h0000_0000);

    // Enables
    wr(0, 8'h00, 32'h0000_000F);
    rd(0, 8'h00, 32'h0000_000F);
    chk("enables_all", 64'({ep0, ea0, en0, em0}), 64'hF);
    wr(0, 8'h00, 32'h0000_000D);
    chk("enables_no_norm", 64'({ep0, ea0, en0, em0}), 64'hD);
    rd(0, 8'h00, 32'h0000_000D);

    // Normalisation constants
    wr(0, 8'h08, 32'h0000_0001);
    wr(0, 8'h0C, 32'h0000_0001);
    chk("mean_inv", 64'({mean0, inv0}), 64'h0101);
    rd(0, 8'h08, 32'h0000_0001);
    rd(0, 8'h0C, 32'h0000_0001);
    wr(0, 8'h08, 32'hFFFF_FF23);
    rd(0, 8'h08, 32'h0000_0023);
    chk("mean_trunc", 64'(mean0), 64'h23);

    // Start / done handshake
    wr(0, 8'h04, 32'h0000_0001);
    chk("start_set", 64'(start0), 64'd1);
    rd(0, 8'h04, 32'h0000_0001);
    @(posedge clk); #1; done_tpu = 1'b1;
    @(posedge clk); #1; done_tpu = 1'b0;
    chk("start_cleared_by_done", 64'(start0), 64'd0);
    rd(0, 8'h04, 32'h8000_0000);
    wr(0, 8'h04, 32'h0000_0000);
    rd(0, 8'h04, 32'h8000_0000);

    // Start write coincides with done_tpu: write wins
    done_tpu = 1'b1;
    wr(0, 8'h04, 32'h0000_0001);
    done_tpu = 1'b0;
    chk("same_edge_start", 64'(start0), 64'd1);
    rd(0, 8'h04, 32'h0000_0001);

    // Wait states, PRDATA hold, unmapped address
    wr(1, 8'h00, 32'h0000_0005);
    rd(1, 8'h00, 32'h0000_0005);
    chk("prdata_hold_a", 64'(prdata1), 64'h5);
    @(posedge clk); #1;
    chk("prdata_hold_b", 64'(prdata1), 64'h5);
    wr(1, 8'h10, 32'hFFFF_FFFF);
    chk("unmapped_no_change", 64'({ep1, ea1, en1, em1, mean1, inv1, start1}), 64'({4'h5, 8'h00, 8'h00, 1'b0}));
    rd(1, 8'h10, 32'h0000_0000);
    rd(1, 8'h00, 32'h0000_0005);

    // PSEL dropped before PREADY: write abandoned, PRDATA untouched
    @(posedge clk); #1;
    paddr = 8'h08; pwrite = 1'b1; pwdata = 32'h0000_0077; psel1 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel1 = 1'b0; penable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_mean", 64'(mean1), 64'h00);
    chk("abort_prdata", 64'(prdata1), 64'h5);
    rd(1, 8'h08, 32'h0000_0000);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
